// File: rtl/pipe_hazard_ctrl.sv
// Single stall/flush source for the 5-stage core: issues data_ctrl commands to the four
// pipeline registers and the PC hold, and keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_wr_i,
    input  logic             ex_rf_we_i,
    input  logic             ex_is_load_i,
    input  logic             ex_mc_start_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_wait_i,
    output logic             pc_stall_o,
    output logic [1:0]       ifid_ctrl_o,
    output logic [1:0]       idex_ctrl_o,
    output logic [1:0]       exmem_ctrl_o,
    output logic [1:0]       memwb_ctrl_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int MCW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [1:0] NORMAL = 2'b00;
    localparam logic [1:0] FLUSH  = 2'b01;
    localparam logic [1:0] STOP   = 2'b10;

    typedef enum logic {RUN, MC_STALL} state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu, flush_ev, pc_stall;
    logic [1:0]       ifid, idex, exmem, memwb;

    assign lu = ex_is_load_i & ex_rf_we_i & (ex_wr_i != 5'd0) &
                ((id_use_rs1_i & (id_rs1_i == ex_wr_i)) |
                 (id_use_rs2_i & (id_rs2_i == ex_wr_i)));

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        flush_ev = 1'b0;
        pc_stall = 1'b0;
        ifid     = NORMAL;
        idex     = NORMAL;
        exmem    = NORMAL;
        memwb    = NORMAL;
        if (mem_wait_i) begin
            // Memory wait freezes everything, including a multi-cycle op in progress.
            pc_stall = 1'b1;
            ifid     = STOP;
            idex     = STOP;
            exmem    = STOP;
            memwb    = STOP;
        end else if (state_q == RUN) begin
            if (ex_br_taken_i) begin
                ifid     = FLUSH;
                idex     = FLUSH;
                flush_ev = 1'b1;
            end else if (ex_mc_start_i) begin
                pc_stall = 1'b1;
                ifid     = STOP;
                idex     = STOP;
                exmem    = FLUSH;
                mc_cnt_d = MCW'(MC_LAT - 1);
                state_d  = MC_STALL;
            end else if (lu) begin
                pc_stall = 1'b1;
                ifid     = STOP;
                idex     = FLUSH;
            end
        end else if (mc_cnt_q != '0) begin
            pc_stall = 1'b1;
            ifid     = STOP;
            idex     = STOP;
            exmem    = FLUSH;
            mc_cnt_d = mc_cnt_q - MCW'(1);
        end else begin
            state_d = RUN;
        end
    end

    assign stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush_ev && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced idle while reset is held, whatever the inputs do.
    assign pc_stall_o   = rst_i ? 1'b0   : pc_stall;
    assign ifid_ctrl_o  = rst_i ? NORMAL : ifid;
    assign idex_ctrl_o  = rst_i ? NORMAL : idex;
    assign exmem_ctrl_o = rst_i ? NORMAL : exmem;
    assign memwb_ctrl_o = rst_i ? NORMAL : memwb;
    assign busy_o       = (state_q == MC_STALL);
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic, all checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 6;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0, rst_i = 1'b0;
    logic [4:0]       id_rs1_i, id_rs2_i, ex_wr_i;
    logic             id_use_rs1_i, id_use_rs2_i, ex_rf_we_i, ex_is_load_i;
    logic             ex_mc_start_i, ex_br_taken_i, mem_wait_i;
    logic             pc_stall_o, busy_o;
    logic [1:0]       ifid_ctrl_o, idex_ctrl_o, exmem_ctrl_o, memwb_ctrl_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_wr_i(ex_wr_i), .ex_rf_we_i(ex_rf_we_i), .ex_is_load_i(ex_is_load_i),
        .ex_mc_start_i(ex_mc_start_i), .ex_br_taken_i(ex_br_taken_i), .mem_wait_i(mem_wait_i),
        .pc_stall_o(pc_stall_o), .ifid_ctrl_o(ifid_ctrl_o), .idex_ctrl_o(idex_ctrl_o),
        .exmem_ctrl_o(exmem_ctrl_o), .memwb_ctrl_o(memwb_ctrl_o), .busy_o(busy_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, passed = 0;

    // Model: a multi-cycle op occupies EX until it has seen MC_LAT cycles not lost to a
    // memory wait, then spends one more (non-stalling) cycle leaving EX.
    bit m_mc;
    int m_served, m_sc, m_fc;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_in(input bit ld, input bit we, input int wr, input int r1, input bit u1,
                          input int r2, input bit u2, input bit mc, input bit br, input bit mw);
        ex_is_load_i = ld; ex_rf_we_i = we; ex_wr_i = 5'(wr);
        id_rs1_i = 5'(r1); id_use_rs1_i = u1; id_rs2_i = 5'(r2); id_use_rs2_i = u2;
        ex_mc_start_i = mc; ex_br_taken_i = br; mem_wait_i = mw;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int e_pc, e_if, e_id, e_ex, e_wb;
        bit hz, fl;
        @(negedge clk_i);
        hz = ex_is_load_i && ex_rf_we_i && ex_wr_i != 0 &&
             ((id_use_rs1_i && id_rs1_i == ex_wr_i) || (id_use_rs2_i && id_rs2_i == ex_wr_i));
        e_pc = 0; e_if = 0; e_id = 0; e_ex = 0; e_wb = 0; fl = 0;
        chk("busy", busy_o, m_mc);
        chk("stall_cnt", stall_cnt_o, m_sc);
        chk("flush_cnt", flush_cnt_o, m_fc);
        if (mem_wait_i) begin
            e_pc = 1; e_if = 2; e_id = 2; e_ex = 2; e_wb = 2;
        end else if (m_mc) begin
            if (m_served < MC_LAT) begin
                e_pc = 1; e_if = 2; e_id = 2; e_ex = 1; m_served++;
            end else m_mc = 0;
        end else if (ex_br_taken_i) begin
            e_if = 1; e_id = 1; fl = 1;
        end else if (ex_mc_start_i) begin
            e_pc = 1; e_if = 2; e_id = 2; e_ex = 1; m_mc = 1; m_served = 1;
        end else if (hz) begin
            e_pc = 1; e_if = 2; e_id = 1;
        end
        chk("pc_stall", pc_stall_o, e_pc);
        chk("ifid", ifid_ctrl_o, e_if);
        chk("idex", idex_ctrl_o, e_id);
        chk("exmem", exmem_ctrl_o, e_ex);
        chk("memwb", memwb_ctrl_o, e_wb);
        if (e_pc == 1 && m_sc < SAT) m_sc++;
        if (fl && m_fc < SAT) m_fc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_pc"}, pc_stall_o, 0);
        chk({tag, "_ctrl"}, {ifid_ctrl_o, idex_ctrl_o, exmem_ctrl_o, memwb_ctrl_o}, 0);
        chk({tag, "_scnt"}, stall_cnt_o, 0);
        chk({tag, "_fcnt"}, flush_cnt_o, 0);
        m_mc = 0; m_served = 0; m_sc = 0; m_fc = 0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #12;
        check_reset_state("reset");
        @(posedge clk_i); #1 rst_i = 1'b0;

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble.
        set_in(1, 1, 5, 5, 1, 1, 1, 0, 0, 0); cycle();
        idle(1);
        chk("lu_stall_cnt", stall_cnt_o, 1);
        // Load into x0, and a non-writing matching op: no stall.
        set_in(1, 1, 0, 0, 1, 0, 1, 0, 0, 0); cycle();
        set_in(1, 0, 7, 7, 1, 7, 1, 0, 0, 0); cycle();
        // rs2 match only.
        set_in(1, 1, 9, 3, 1, 9, 1, 0, 0, 0); cycle();
        // Branch beats a simultaneous load-use.
        set_in(1, 1, 5, 5, 1, 0, 0, 0, 1, 0); cycle();
        idle(1);
        chk("br_flush_cnt", flush_cnt_o, 1);
        // Multi-cycle op: MC_LAT stall cycles, release on the next.
        set_in(1, 1, 5, 5, 1, 0, 0, 1, 0, 0); cycle();
        for (int i = 0; i < MC_LAT; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
        end
        idle(1);
        chk("mc_stall_cnt", stall_cnt_o, 2 + MC_LAT);
        // Two memory-wait cycles inside MC_STALL push the release out by two.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle(MC_LAT + 1);
        chk("mcw_stall_cnt", stall_cnt_o, 2 + 2 * MC_LAT + 2);

        // Drive both counters into saturation.
        for (int i = 0; i < SAT + 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cycle();
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
        end
        idle(1);
        chk("sat_stall", stall_cnt_o, SAT);
        chk("sat_flush", flush_cnt_o, SAT);

        // Reset in the middle of MC_STALL.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle(1);
        chk("pre_rst_busy", busy_o, 1);
        rst_i = 1'b1;
        #2;
        check_reset_state("mid_rst");
        @(posedge clk_i); #1 rst_i = 1'b0;
        idle(2);

        // Random traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
